// File: rtl/avalon_mem_responder.sv
// ---------------------------------------------------------------------------
// avalon_mem_responder
//
// Avalon-MM slave memory model. It serves word reads and byte-enabled writes.
// Every transfer is stretched by a programmable number of waitrequest stall
// cycles. A side preload port fills the memory before the CPU starts.
//
// Parameters:
//   DEPTH_LOG2  - log2 of memory depth in 32-bit words. inst_addr is 8 bits
//                 wide, so the preload port can reach at most 64 words.
//   WAIT_CYCLES - WAIT-state cycles per transfer (0 allowed).
//
// Ports:
//   clk            clock; all state changes on the rising edge
//   reset          asynchronous, active-low reset
//   address        byte address; word index = address[DEPTH_LOG2+1:2]
//   write / read   request strobes from the master
//   waitrequest    stall; the master holds the request while this is high
//   writedata      write data
//   byteenable     lane enables; bit i selects writedata[8i+7:8i]
//   readdata       registered read data, valid during the ACK cycle
//   inst_input     preload enable; it freezes the bus FSM while high
//   inst_addr      preload byte address
//   instruction    preload word (always written as a full word)
//   protocol_error sticky flag: read and write were requested together
// ---------------------------------------------------------------------------
module avalon_mem_responder #(
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        write,
  input  logic        read,
  output logic        waitrequest,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  input  logic        inst_input,
  input  logic [7:0]  inst_addr,
  input  logic [31:0] instruction,
  output logic        protocol_error
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // The counter only ever holds WAIT_CYCLES-1 down to 0.
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_t;

  state_t                state_reg;
  logic [CW-1:0]         cnt_reg;
  logic                  is_write_reg;   // operation latched at the IDLE decision
  logic [31:0]           readdata_reg;
  logic                  perr_reg;
  logic [31:0]           mem [DEPTH];

  logic                  req;
  logic [DEPTH_LOG2-1:0] bus_idx;
  logic [DEPTH_LOG2-1:0] pre_idx;
  logic [31:0]           cur_word;
  logic [31:0]           merged_word;

  assign req     = read | write;
  assign bus_idx = address[DEPTH_LOG2+1:2];
  assign pre_idx = inst_addr[DEPTH_LOG2+1:2];
  assign cur_word = mem[bus_idx];

  // A preload keeps the master stalled, even when the FSM is frozen in ACK.
  assign waitrequest    = req && ((state_reg != ST_ACK) || inst_input);
  assign readdata       = readdata_reg;
  assign protocol_error = perr_reg;

  // Byte-lane merge for a write: disabled lanes keep the stored bytes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merged_word[8*gi +: 8] = byteenable[gi] ? writedata[8*gi +: 8]
                                                     : cur_word[8*gi +: 8];
    end
  endgenerate

  // The memory needs a full clear on reset, so it is built from registers
  // rather than block RAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      is_write_reg <= 1'b0;
      readdata_reg <= '0;
      perr_reg     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (inst_input) begin
      // Preload wins. The FSM and the counter hold their values.
      mem[pre_idx] <= instruction;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req) begin
            is_write_reg <= write;     // read+write together counts as a write
            if (read && write) begin
              perr_reg <= 1'b1;
            end
            if (WAIT_CYCLES == 0) begin
              state_reg <= ST_ACK;
              if (!write) begin
                readdata_reg <= cur_word;
              end
            end else begin
              state_reg <= ST_WAIT;
              cnt_reg   <= CNT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (!req) begin
            state_reg <= ST_IDLE;      // master aborted; nothing is committed
          end else if (cnt_reg == '0) begin
            state_reg <= ST_ACK;
            if (!is_write_reg) begin
              readdata_reg <= cur_word;
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_ACK: begin
          state_reg <= ST_IDLE;
          if (is_write_reg) begin
            mem[bus_idx] <= merged_word;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
